hazard_int_ctrl: RTL and testbench

HAZARD_INT_CTRL -- requirements
Module: hazard_int_ctrl

---
 rtl/hazard_int_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_int_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_int_ctrl.sv
// rtl/hazard_int_ctrl.sv - pipeline hazard stall/flush control with interrupt micro-op injection
module hazard_int_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] dec_rs,
  input  logic [2:0] dec_rd,
  input  logic       dec_uses_rs,
  input  logic       dec_uses_rd,
  input  logic [2:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       int1,
  input  logic       int2,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       bubble_exec,
  output logic       flush_fd,
  output logic       int_inject,
  output logic [1:0] int_step,
  output logic       int1_out,
  output logic       int2_out,
  output logic       int_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_PC  = 2'd1,
    PUSH_CCR = 2'd2,
    JUMP     = 2'd3
  } state_t;

  state_t state;
  logic   pend1, pend2;
  logic   int1_q, int2_q;
  logic   src1, src2;

  logic   load_use;
  logic   in_idle;
  logic   entry;
  logic   rise1, rise2;

  // Hazard detection and interrupt entry qualification; only meaningful in IDLE
  always_comb begin
    load_use = ex_mem_read &&
               ((dec_uses_rs && (dec_rs == ex_rd)) ||
                (dec_uses_rd && (dec_rd == ex_rd)));
    in_idle  = (state == IDLE);
    entry    = in_idle && (pend1 || pend2) && !load_use && !ex_branch_taken;
    rise1    = int1 && !int1_q;
    rise2    = int2 && !int2_q;
  end

  // Injection sequencer, edge detectors, pending bits and latched source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pend1  <= 1'b0;
      pend2  <= 1'b0;
      int1_q <= 1'b0;
      int2_q <= 1'b0;
      src1   <= 1'b0;
      src2   <= 1'b0;
    end else begin
      int1_q <= int1;
      int2_q <= int2;
      // A fresh edge arriving on the entry edge re-arms the bit being serviced
      pend1  <= rise1 || (pend1 && !(entry && pend1));
      pend2  <= rise2 || (pend2 && !(entry && !pend1));
      case (state)
        IDLE: begin
          if (entry) begin
            state <= PUSH_PC;
            src1  <= pend1;
            src2  <= !pend1;
          end
        end
        PUSH_PC:  state <= PUSH_CCR;
        PUSH_CCR: state <= JUMP;
        JUMP:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Output decode; hazard response is same-cycle so these follow the live inputs
  always_comb begin
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    bubble_exec  = 1'b0;
    flush_fd     = 1'b0;
    int_inject   = 1'b0;
    int_step     = 2'd0;
    int1_out     = 1'b0;
    int2_out     = 1'b0;
    int_busy     = 1'b0;
    if (!reset) begin
      if (in_idle) begin
        if (ex_branch_taken) begin
          flush_fd    = 1'b1;
          bubble_exec = 1'b1;
        end else if (load_use) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          bubble_exec  = 1'b1;
        end
      end else begin
        int_busy     = 1'b1;
        int_inject   = 1'b1;
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        int1_out     = src1;
        int2_out     = src2;
        case (state)
          PUSH_PC:  int_step = 2'd0;
          PUSH_CCR: int_step = 2'd1;
          default: begin
            int_step = 2'd2;
            flush_fd = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_int_ctrl.sv
// tb/tb_hazard_int_ctrl.sv - randomized and directed self-checking bench for hazard_int_ctrl
module tb_hazard_int_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] dec_rs, dec_rd, ex_rd;
  logic       dec_uses_rs, dec_uses_rd, ex_mem_read, ex_branch_taken;
  logic       int1, int2;
  logic       stall_fetch, stall_decode, bubble_exec, flush_fd, int_inject;
  logic [1:0] int_step;
  logic       int1_out, int2_out, int_busy;

  int total = 0;
  int bad   = 0;

  // Reference model: seq_pos is -1 when idle, otherwise the micro-op number
  int m_seq_pos;
  bit m_pend1, m_pend2, m_prev1, m_prev2;
  int m_src;
  bit m_entry;

  hazard_int_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_rs(dec_rs), .dec_rd(dec_rd),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rd(dec_uses_rd),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .int1(int1), .int2(int2),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .bubble_exec(bubble_exec), .flush_fd(flush_fd),
    .int_inject(int_inject), .int_step(int_step),
    .int1_out(int1_out), .int2_out(int2_out), .int_busy(int_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seq_pos = -1;
    m_pend1 = 0; m_pend2 = 0;
    m_prev1 = 0; m_prev2 = 0;
    m_src = 0;
  endtask

  task automatic check_outputs();
    bit hz;
    bit e_sf, e_sd, e_bub, e_fl, e_inj, e_i1, e_i2, e_busy;
    logic [1:0] e_step;
    e_sf = 0; e_sd = 0; e_bub = 0; e_fl = 0; e_inj = 0;
    e_i1 = 0; e_i2 = 0; e_busy = 0; e_step = 0;
    m_entry = 0;
    if (m_seq_pos < 0) begin
      hz = ex_mem_read && ((dec_uses_rs && dec_rs == ex_rd) || (dec_uses_rd && dec_rd == ex_rd));
      if (ex_branch_taken) begin
        e_fl = 1; e_bub = 1;
      end else if (hz) begin
        e_sf = 1; e_sd = 1; e_bub = 1;
      end
      m_entry = (m_pend1 || m_pend2) && !hz && !ex_branch_taken;
    end else begin
      e_busy = 1; e_inj = 1; e_sf = 1; e_sd = 1;
      e_step = 2'(m_seq_pos);
      e_fl = (m_seq_pos == 2);
      e_i1 = (m_src == 1);
      e_i2 = (m_src == 2);
    end
    chk("stall_fetch",  {1'b0, stall_fetch},  {1'b0, e_sf});
    chk("stall_decode", {1'b0, stall_decode}, {1'b0, e_sd});
    chk("bubble_exec",  {1'b0, bubble_exec},  {1'b0, e_bub});
    chk("flush_fd",     {1'b0, flush_fd},     {1'b0, e_fl});
    chk("int_inject",   {1'b0, int_inject},   {1'b0, e_inj});
    chk("int_step",     int_step,             e_step);
    chk("int1_out",     {1'b0, int1_out},     {1'b0, e_i1});
    chk("int2_out",     {1'b0, int2_out},     {1'b0, e_i2});
    chk("int_busy",     {1'b0, int_busy},     {1'b0, e_busy});
  endtask

  task automatic model_clock();
    bit r1, r2;
    r1 = int1 && !m_prev1;
    r2 = int2 && !m_prev2;
    if (m_entry) begin
      m_seq_pos = 0;
      if (m_pend1) begin m_src = 1; m_pend1 = 0; end
      else begin m_src = 2; m_pend2 = 0; end
    end else if (m_seq_pos >= 0) begin
      m_seq_pos = (m_seq_pos == 2) ? -1 : m_seq_pos + 1;
    end
    m_pend1 = m_pend1 || r1;
    m_pend2 = m_pend2 || r2;
    m_prev1 = int1;
    m_prev2 = int2;
  endtask

  // Inputs are already driven (just after a rising edge); check, then clock
  task automatic cyc();
    #3;
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic quiet();
    dec_rs = 0; dec_rd = 0; ex_rd = 0;
    dec_uses_rs = 0; dec_uses_rd = 0; ex_mem_read = 0; ex_branch_taken = 0;
  endtask

  task automatic load_use_rs3();
    ex_mem_read = 1; ex_rd = 3; dec_uses_rs = 1; dec_rs = 3;
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    #1;
    chk("rst_stall_fetch", {1'b0, stall_fetch}, 2'd0);
    chk("rst_bubble",      {1'b0, bubble_exec}, 2'd0);
    chk("rst_flush",       {1'b0, flush_fd},    2'd0);
    chk("rst_inject",      {1'b0, int_inject},  2'd0);
    chk("rst_busy",        {1'b0, int_busy},    2'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    quiet();
    int1 = 0; int2 = 0;
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    // hazard outputs must stay low under reset even with a live hazard
    load_use_rs3();
    ex_branch_taken = 1;
    #1;
    chk("reset_bubble", {1'b0, bubble_exec}, 2'd0);
    chk("reset_flush",  {1'b0, flush_fd},    2'd0);
    @(posedge clk);
    #1;
    reset = 0;
    quiet();
    cyc();

    // load-use on rs for one cycle, then a non-matching register
    load_use_rs3(); cyc();
    dec_rs = 4;     cyc();
    quiet();        cyc();
    // load-use via rd path
    ex_mem_read = 1; ex_rd = 5; dec_uses_rd = 1; dec_rd = 5; cyc();
    quiet(); cyc();

    // branch overrides load-use
    load_use_rs3(); ex_branch_taken = 1; cyc();
    quiet(); cyc();

    // int2 pulse in idle
    int2 = 1; cyc();
    int2 = 0;
    repeat (6) cyc();

    // simultaneous int1/int2 edges
    int1 = 1; int2 = 1; cyc();
    int1 = 0; int2 = 0;
    repeat (10) cyc();

    // int1 pending while load-use hazard held, entry deferred
    int1 = 1; cyc();
    int1 = 0;
    load_use_rs3(); cyc();
    cyc();
    quiet(); repeat (5) cyc();

    // edges during injection are captured and serviced later
    int1 = 1; cyc();
    int1 = 0; cyc();
    int2 = 1; load_use_rs3(); ex_branch_taken = 1; cyc();
    int2 = 0; cyc();
    quiet(); repeat (6) cyc();

    // reset during PUSH_CCR aborts the sequence
    int1 = 1; cyc();
    int1 = 0; cyc();
    cyc();
    do_reset();
    repeat (5) cyc();

    // int level held high across reset deassertion
    int2 = 1;
    do_reset();
    repeat (6) cyc();
    int2 = 0; cyc();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      dec_rs          = 3'($urandom_range(0, 7));
      dec_rd          = 3'($urandom_range(0, 7));
      ex_rd           = 3'($urandom_range(0, 7));
      dec_uses_rs     = 1'($urandom_range(0, 1));
      dec_uses_rd     = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) int1 = ~int1;
      if ($urandom_range(0, 4) == 0) int2 = ~int2;
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
